cosine_bank_accumulator: RTL

- Streams one frame of I spectral samples and accumulates, per channel nu = 0..NU_VALUES-1, a running sum of data * cos(2*pi*nu*i/I).
- Emits the per-sample running sums for BRAM storage, plus an end-of-frame pulse carrying the final sums.
- Parametrised successor of the fixed 3-channel T-table stage: arbitrary channel count, widths and frame length, with a gap-tolerant frame FSM and a phase-accumulator coefficient index.
- Sits between the FFT magnitude stream and the T-table BRAM writer.

---
 rtl/cosine_bank_accumulator.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cosine_bank_accumulator.sv
// cosine_bank_accumulator
// Streams one frame of I unsigned samples and keeps, for each harmonic channel
// nu, a running sum of data * cos(2*pi*nu*i/I). Every accepted sample yields
// one output beat carrying all running sums three cycles later; the beat for
// i = I-1 also raises frame_done. Frames may contain input gaps, and the next
// frame may follow the previous one without an idle cycle.
// Optional feature: define COSACC_SATURATE_EN to make the accumulators saturate
// and to add the sticky per-frame sat_flag output.
// The coefficient table is computed at elaboration with the same rounding that
// generates COS_FILE, so the design does not depend on the file being present.
module cosine_bank_accumulator #(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = 32,
  parameter int I         = 160,
  parameter int NU_VALUES = 3,
  parameter int SHIFT     = 15,
  parameter     COS_FILE  = "cos_table.mem"
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       clear_in,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  output logic [$clog2(I)-1:0]       out_addr,
  output logic [NU_VALUES*ACC_W-1:0] out_sums,
  output logic                       frame_done,
  output logic                       busy
`ifdef COSACC_SATURATE_EN
  ,
  output logic [NU_VALUES-1:0]       sat_flag
`endif
);

  localparam int                 IDX_W    = $clog2(I);
  localparam int                 PROD_W   = DATA_W + 1 + COEF_W;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(I - 1);
  localparam logic [IDX_W:0]     I_EXT    = (IDX_W + 1)'(I);
  localparam real                PI       = 3.14159265358979323846;

  if (NU_VALUES < 1 || NU_VALUES > 8 || $bits(COS_FILE) == 0) begin : g_bad_cfg
    $error("cosine_bank_accumulator: NU_VALUES must be 1..8 and COS_FILE non-empty");
  end

  // Entry k = round((2^(COEF_W-1)-1) * cos(2*pi*k/I)), halves rounded away from zero.
  function automatic logic signed [COEF_W-1:0] cos_coef(input int k);
    real amp;
    real x;
    amp = (2.0 ** (COEF_W - 1)) - 1.0;
    x   = amp * $cos(2.0 * PI * real'(k) / real'(I));
    return (x >= 0.0) ? COEF_W'($rtoi(x + 0.5)) : COEF_W'($rtoi(x - 0.5));
  endfunction

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  // NOTE: the cosine ROM is a constant table and needs no reset; every register
  // array below is reset so the whole pipeline comes up in a known state.
  logic signed [COEF_W-1:0] w_rom [I];
  for (genvar k = 0; k < I; k++) begin : g_rom
    assign w_rom[k] = cos_coef(k);
  end

  state_t                   r_state, w_state_next;
  logic                     w_busy_next;
  logic                     w_accept;
  logic                     w_last_in;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         r_phase      [NU_VALUES];
  logic [IDX_W:0]           w_phase_sum  [NU_VALUES];
  logic [IDX_W-1:0]         w_phase_next [NU_VALUES];

  logic                     r_s1_valid, r_s1_last;
  logic [DATA_W-1:0]        r_s1_data;
  logic [IDX_W-1:0]         r_s1_addr;
  logic signed [COEF_W-1:0] r_s1_coef [NU_VALUES];
  logic signed [PROD_W-1:0] w_prod    [NU_VALUES];
  logic signed [ACC_W-1:0]  w_prod_acc[NU_VALUES];

  logic                     r_s2_valid, r_s2_last;
  logic [IDX_W-1:0]         r_s2_addr;
  logic signed [ACC_W-1:0]  r_s2_prod [NU_VALUES];

  logic signed [ACC_W-1:0]  r_acc     [NU_VALUES];
  logic signed [ACC_W-1:0]  w_sum     [NU_VALUES];
`ifdef COSACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0]    w_wide    [NU_VALUES];
  logic [NU_VALUES-1:0]     w_sat;
`endif

  // A clear in the same cycle as a sample wins and the sample is dropped.
  assign w_accept  = in_valid && !clear_in;
  assign w_last_in = (r_idx == LAST_IDX);

  // Frame state and busy register.
  // NOTE: sequential state is written with <= only, so every register samples
  // the values of the previous cycle regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      busy    <= w_busy_next;
    end
  end

  // Frame FSM next state; busy lasts until the final beat has left the pipeline.
  // NOTE: defaults come first so no path leaves a variable unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_busy_next  = busy;
    if (clear_in) begin
      w_state_next = S_IDLE;
      w_busy_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && !w_last_in) w_state_next = S_ACCUM;
        S_ACCUM: if (w_accept && w_last_in)  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
      if (w_accept || r_state == S_ACCUM) w_busy_next = 1'b1;
      else if (frame_done)                w_busy_next = 1'b0;
    end
  end

  // Phase accumulators: phase[nu] = (nu*i) mod I by repeated add-and-wrap.
  always_comb begin
    for (int nu = 0; nu < NU_VALUES; nu++) begin
      w_phase_sum[nu]  = {1'b0, r_phase[nu]} + (IDX_W + 1)'(nu);
      w_phase_next[nu] = (w_phase_sum[nu] >= I_EXT) ? IDX_W'(w_phase_sum[nu] - I_EXT)
                                                    : IDX_W'(w_phase_sum[nu]);
    end
  end

  // Stage 1: sample index/phase advance, data capture and ROM lookup.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_data  <= '0;
      r_s1_addr  <= '0;
      for (int nu = 0; nu < NU_VALUES; nu++) begin
        r_phase[nu]   <= '0;
        r_s1_coef[nu] <= '0;
      end
    end else if (clear_in) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      for (int nu = 0; nu < NU_VALUES; nu++) r_phase[nu] <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data <= in_data;
        r_s1_addr <= r_idx;
        r_s1_last <= w_last_in;
        r_idx     <= w_last_in ? '0 : r_idx + 1'b1;
        for (int nu = 0; nu < NU_VALUES; nu++) begin
          r_s1_coef[nu] <= w_rom[r_phase[nu]];
          r_phase[nu]   <= w_last_in ? '0 : w_phase_next[nu];
        end
      end
    end
  end

  // Signed product of zero-extended data and coefficient, scaled to ACC_W.
  always_comb begin
    for (int nu = 0; nu < NU_VALUES; nu++) begin
      w_prod[nu]     = PROD_W'($signed({1'b0, r_s1_data})) * PROD_W'(r_s1_coef[nu]);
      w_prod_acc[nu] = ACC_W'(w_prod[nu] >>> SHIFT);
    end
  end

  // Stage 2: register the scaled products.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_addr  <= '0;
      for (int nu = 0; nu < NU_VALUES; nu++) r_s2_prod[nu] <= '0;
    end else begin
      r_s2_valid <= r_s1_valid && !clear_in;
      if (r_s1_valid) begin
        r_s2_last <= r_s1_last;
        r_s2_addr <= r_s1_addr;
        for (int nu = 0; nu < NU_VALUES; nu++) r_s2_prod[nu] <= w_prod_acc[nu];
      end
    end
  end

  // Accumulator update: wraps by default, saturates when the option is built in.
  always_comb begin
`ifdef COSACC_SATURATE_EN
    w_sat = '0;
    for (int nu = 0; nu < NU_VALUES; nu++) begin
      w_wide[nu] = (ACC_W + 1)'(r_acc[nu]) + (ACC_W + 1)'(r_s2_prod[nu]);
      w_sum[nu]  = w_wide[nu][ACC_W-1:0];
      if (w_wide[nu][ACC_W] != w_wide[nu][ACC_W-1]) begin
        w_sat[nu] = 1'b1;
        w_sum[nu] = w_wide[nu][ACC_W] ? ACC_MIN : ACC_MAX;
      end
    end
`else
    for (int nu = 0; nu < NU_VALUES; nu++) w_sum[nu] = r_acc[nu] + r_s2_prod[nu];
`endif
  end

  // Stage 3: accumulate, present running sums, auto-clear after the last sample.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_sums   <= '0;
      frame_done <= 1'b0;
      for (int nu = 0; nu < NU_VALUES; nu++) r_acc[nu] <= '0;
`ifdef COSACC_SATURATE_EN
      sat_flag   <= '0;
`endif
    end else if (clear_in) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int nu = 0; nu < NU_VALUES; nu++) r_acc[nu] <= '0;
`ifdef COSACC_SATURATE_EN
      sat_flag   <= '0;
`endif
    end else begin
      out_valid  <= r_s2_valid;
      frame_done <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        out_addr <= r_s2_addr;
        for (int nu = 0; nu < NU_VALUES; nu++) begin
          out_sums[nu*ACC_W +: ACC_W] <= w_sum[nu];
          r_acc[nu]                   <= r_s2_last ? '0 : w_sum[nu];
        end
`ifdef COSACC_SATURATE_EN
        sat_flag <= (r_s2_addr == '0) ? w_sat : (sat_flag | w_sat);
`endif
      end
    end
  end

endmodule
